// File: rtl/ram_helper_pkg.sv
// Shared definitions for the RAM-helper initiator bridge.
// Holds the address/data geometry, the bridge FSM state encoding, the
// request/response payload structs and the burst index-advance function.
package ram_helper_pkg;

  localparam int PADDR_W = 56;
  localparam int IDX_W   = PADDR_W - 4;
  localparam int DATA_W  = 128;
  localparam int MASK_W  = DATA_W / 8;
  localparam int LEN_W   = 3;
  // One extra bit so the beat counter can reach len+1 (burst fully issued).
  localparam int CNT_W   = LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    WRESP = 2'd3
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [LEN_W-1:0] len;
    logic             wrap;
    logic             write;
  } req_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              write;
    logic              err;
  } rsp_t;

  // Word index of the next beat. Wrapping only applies to power-of-two
  // bursts (2, 4 or 8 beats); any other length with wrap set walks linearly.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic [LEN_W-1:0] len,
                                                input logic             wrap);
    logic [IDX_W-1:0] inc;
    logic [IDX_W-1:0] lmask;
    inc   = idx + IDX_W'(1);
    lmask = {{(IDX_W-LEN_W){1'b0}}, len};
    if (wrap && (len == 3'd1 || len == 3'd3 || len == 3'd7)) begin
      return (idx & ~lmask) | (inc & lmask);
    end
    return inc;
  endfunction

endpackage

// File: rtl/ram_helper_rsp_slot.sv
// One-entry response register with a valid/ready output handshake.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load, load_rsp  capture a new response (takes priority over draining)
//   ready           downstream accepts the held response
//   valid, rsp      held response and its valid flag
module ram_helper_rsp_slot
  import ram_helper_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  rsp_t load_rsp,
  input  logic ready,
  output logic valid,
  output rsp_t rsp
);

  logic vld_p1;
  rsp_t rsp_p1;

  // ---- stage p1: response register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      rsp_p1 <= '0;
    end else if (load) begin
      vld_p1 <= 1'b1;
      rsp_p1 <= load_rsp;
    end else if (vld_p1 && ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign valid = vld_p1;
  assign rsp   = rsp_p1;

endmodule

// File: rtl/ram_helper_bridge.sv
// Initiator side of the simulation RAM-helper interface.
// Accepts one burst request at a time, drives the helper port one 128-bit
// beat per cycle and returns read beats or a single write acknowledgement.
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   req_*                               burst request channel (valid/ready)
//   wdat_*                              write beat channel (valid/ready)
//   rsp_*                               response channel (valid/ready)
//   ram_en/ridx/rdata/widx/wdata/wmask/wen  helper port; rdata is
//                                       combinational from en/ridx, writes
//                                       commit at the rising edge
module ram_helper_bridge
  import ram_helper_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [PADDR_W-1:0]  req_addr,
  input  logic                req_write,
  input  logic [LEN_W-1:0]    req_len,
  input  logic                req_wrap,
  input  logic                wdat_valid,
  output logic                wdat_ready,
  input  logic [DATA_W-1:0]   wdat_data,
  input  logic [MASK_W-1:0]   wdat_mask,
  input  logic                wdat_last,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_last,
  output logic                rsp_write,
  output logic                rsp_err,
  output logic                ram_en,
  output logic [IDX_W-1:0]    ram_ridx,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [IDX_W-1:0]    ram_widx,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic [MASK_W-1:0]   ram_wmask,
  output logic                ram_wen
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;
  logic             wrap_q;
  logic             err_q;
  logic [IDX_W-1:0] ridx_hold_q;
  logic [IDX_W-1:0] widx_hold_q;

  req_t req_in;
  rsp_t slot_in, slot_out;
  logic slot_load;

  logic req_hs, rsp_hs;
  logic in_range, at_last;
  logic rd_issue, wr_beat, beat_mismatch;

  // Byte offset within a beat is irrelevant to the helper.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[3:0];

  assign req_in = '{idx:   req_addr[PADDR_W-1:4],
                    len:   req_len,
                    wrap:  req_wrap,
                    write: req_write};

  assign req_ready = (state_q == IDLE);
  assign req_hs    = req_valid && req_ready;
  assign rsp_hs    = rsp_valid && rsp_ready;

  assign in_range  = (cnt_q <= {1'b0, len_q});
  assign at_last   = (cnt_q == {1'b0, len_q});

  // A read beat is only fetched when the slot is free or drains this cycle,
  // so a stalled response never gets overwritten.
  assign rd_issue      = (state_q == READ) && in_range && (!rsp_valid || rsp_ready);
  assign wr_beat       = (state_q == WRITE) && wdat_valid;
  assign beat_mismatch = (wdat_last != at_last);

  always_comb begin
    state_d    = state_q;
    ram_en     = 1'b0;
    ram_wen    = 1'b0;
    wdat_ready = 1'b0;
    ram_wdata  = '0;
    ram_wmask  = '0;
    slot_load  = 1'b0;
    slot_in    = '0;
    unique case (state_q)
      IDLE: begin
        if (req_hs) state_d = req_in.write ? WRITE : READ;
      end
      READ: begin
        ram_en = rd_issue;
        if (rd_issue) begin
          slot_load    = 1'b1;
          slot_in.data = ram_rdata;
          slot_in.last = at_last;
        end
        if (rsp_hs && rsp_last) state_d = IDLE;
      end
      WRITE: begin
        wdat_ready = 1'b1;
        ram_en     = wdat_valid;
        ram_wen    = wdat_valid;
        ram_wdata  = wdat_data;
        ram_wmask  = wdat_mask;
        // The request length decides the burst end; wdat_last is only
        // cross-checked and reported through the ack's error flag.
        if (wdat_valid && at_last) begin
          state_d       = WRESP;
          slot_load     = 1'b1;
          slot_in.write = 1'b1;
          slot_in.last  = 1'b1;
          slot_in.err   = err_q | beat_mismatch;
        end
      end
      WRESP: begin
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outside their own burst phase the indices show the last value driven.
  always_comb begin
    ram_ridx = (state_q == READ)  ? idx_q : ridx_hold_q;
    ram_widx = (state_q == WRITE) ? idx_q : widx_hold_q;
  end

  // ---- stage p0: burst control registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
      ridx_hold_q <= '0;
      widx_hold_q <= '0;
    end else begin
      state_q <= state_d;
      if (req_hs) begin
        idx_q  <= req_in.idx;
        len_q  <= req_in.len;
        wrap_q <= req_in.wrap;
        cnt_q  <= '0;
        err_q  <= 1'b0;
      end else if (rd_issue || wr_beat) begin
        idx_q <= next_idx(idx_q, len_q, wrap_q);
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (wr_beat) err_q <= err_q | beat_mismatch;
      if (state_q == READ)  ridx_hold_q <= idx_q;
      if (state_q == WRITE) widx_hold_q <= idx_q;
    end
  end

  // ---- stage p1: response slot ----
  ram_helper_rsp_slot u_rsp_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (slot_load),
    .load_rsp (slot_in),
    .ready    (rsp_ready),
    .valid    (rsp_valid),
    .rsp      (slot_out)
  );

  assign rsp_data  = slot_out.data;
  assign rsp_last  = slot_out.last;
  assign rsp_write = slot_out.write;
  assign rsp_err   = slot_out.err;

endmodule

// File: tb/tb_ram_helper_bridge.sv
// Testbench for ram_helper_bridge: a helper RAM model on the DUT's helper
// port, a spec-level reference memory and burst index model, a table of
// directed bursts, hand-written reset/readback sequences and random bursts.
module tb_ram_helper_bridge;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_write, req_wrap;
  logic [55:0]  req_addr;
  logic [2:0]   req_len;
  logic         wdat_valid, wdat_ready, wdat_last;
  logic [127:0] wdat_data;
  logic [15:0]  wdat_mask;
  logic         rsp_valid, rsp_ready, rsp_last, rsp_write, rsp_err;
  logic [127:0] rsp_data;
  logic         ram_en, ram_wen;
  logic [51:0]  ram_ridx, ram_widx;
  logic [127:0] ram_rdata, ram_wdata;
  logic [15:0]  ram_wmask;

  always #5 clk = ~clk;

  ram_helper_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_len(req_len), .req_wrap(req_wrap),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
    .wdat_mask(wdat_mask), .wdat_last(wdat_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_write(rsp_write), .rsp_err(rsp_err),
    .ram_en(ram_en), .ram_ridx(ram_ridx), .ram_rdata(ram_rdata),
    .ram_widx(ram_widx), .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
    .ram_wen(ram_wen)
  );

  // Helper RAM (low 10 index bits) and the bench's own reference copy.
  logic [127:0] hmem    [0:1023];
  logic [127:0] ref_mem [0:1023];
  logic         pre_en = 1'b0;
  logic [9:0]   pre_idx = '0;
  logic [127:0] pre_data = '0;

  assign ram_rdata = ram_en ? hmem[ram_ridx[9:0]] : '0;

  always @(posedge clk) begin
    if (pre_en) hmem[pre_idx] <= pre_data;
    else if (ram_en && ram_wen) begin
      for (int b = 0; b < 16; b++)
        if (ram_wmask[b]) hmem[ram_widx[9:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
  end

  // Every helper access seen: {wen, index}.
  logic [52:0] acc_q[$];
  always begin
    @(negedge clk);
    #2;
    if (rst_n && ram_en) acc_q.push_back({ram_wen, ram_wen ? ram_widx : ram_ridx});
  end

  int checks = 0;
  int failures = 0;
  logic [127:0] last_rd;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s bound expired", nm);
  endtask

  function automatic logic [127:0] init_word(input int i);
    if (i >= 256 && i <= 259) return {32{4'(i - 246)}};
    return {32'hC0DE0000 | 32'(i), ~32'(i), 32'(i) * 32'd2654435761, 32'h5A5A5A5A ^ 32'(i)};
  endfunction

  // Index of beat k: wrapping bursts stay inside the aligned block of len+1 words.
  function automatic logic [51:0] ref_idx(input logic [51:0] base, input int len,
                                          input bit wrap, input int k);
    logic [51:0] sz, start;
    if (wrap && (len == 1 || len == 3 || len == 7)) begin
      sz    = 52'(len + 1);
      start = base - (base % sz);
      return start + ((base - start + 52'(k)) % sz);
    end
    return base + 52'(k);
  endfunction

  task automatic ref_write(input logic [51:0] idx, input logic [127:0] d, input logic [15:0] m);
    for (int b = 0; b < 16; b++)
      if (m[b]) ref_mem[idx[9:0]][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic send_req(input logic [55:0] addr, input bit wr, input logic [2:0] len, input bit wrap);
    int w;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_len = len; req_wrap = wrap;
    #1;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); #1; w++; end
    if (!req_ready) fail("req_handshake");
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_acc(input logic [51:0] base, input int len, input bit wrap, input bit wr);
    logic [52:0] e;
    check("acc_count", 128'(acc_q.size()), 128'(len + 1));
    for (int i = 0; i <= len; i++) begin
      if (i < acc_q.size()) begin
        e = {wr, ref_idx(base, len, wrap, i)};
        check("acc_idx", acc_q[i], e);
      end
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: stall first beat 3 cycles
  task automatic run_read(input logic [55:0] addr, input logic [2:0] len, input bit wrap, input int mode);
    logic [51:0] base, bi;
    logic [127:0] exp;
    int k, cyc, stall;
    base = addr[55:4]; k = 0; cyc = 0; stall = 0;
    acc_q.delete();
    send_req(addr, 1'b0, len, wrap);
    while (k <= int'(len) && cyc < 200) begin
      case (mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 2) != 0);
        default: rsp_ready = !(rsp_valid && k == 0 && stall < 3);
      endcase
      #1;
      if (cyc == 0) begin
        check("rd_lat_en", ram_en, 1);
        check("rd_lat_vld0", rsp_valid, 0);
      end
      if (cyc == 1) check("rd_lat_vld1", rsp_valid, 1);
      bi  = ref_idx(base, int'(len), wrap, k);
      exp = ref_mem[bi[9:0]];
      if (mode == 2 && rsp_valid && !rsp_ready) begin
        check("rd_stall_en", ram_en, 0);
        check("rd_stall_data", rsp_data, exp);
        stall++;
      end
      if (rsp_valid && rsp_ready) begin
        check("rd_data", rsp_data, exp);
        check("rd_last", rsp_last, (k == int'(len)));
        check("rd_write", rsp_write, 0);
        if (mode == 0) check("rd_thru", 128'(cyc), 128'(k + 1));
        last_rd = rsp_data;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    rsp_ready = 1'b0;
    if (k <= int'(len)) fail("rd_timeout");
    if (mode == 2) check("rd_stall_cycles", 128'(stall), 128'(3));
    #3;
    check("rd_done_ready", req_ready, 1);
    check_acc(base, int'(len), wrap, 1'b0);
  endtask

  task automatic run_write(input logic [55:0] addr, input logic [2:0] len, input bit wrap,
                           input int last_pos, input bit fixed, input bit exp_err);
    logic [51:0] base, wi;
    int k, cyc, w;
    base = addr[55:4]; k = 0; cyc = 0;
    acc_q.delete();
    send_req(addr, 1'b1, len, wrap);
    while (k <= int'(len) && cyc < 200) begin
      wdat_valid = fixed ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (fixed) begin
        wdat_data = (k == 0) ? {16{8'h11}} : {16{8'h22}};
        wdat_mask = (k == 0) ? 16'hFFFF : 16'h00FF;
      end else begin
        wdat_data = {$urandom, $urandom, $urandom, $urandom};
        wdat_mask = 16'($urandom);
      end
      wdat_last = (k == last_pos);
      #1;
      if (wdat_valid) begin
        check("wr_ready", wdat_ready, 1);
        wi = ref_idx(base, int'(len), wrap, k);
        ref_write(wi, wdat_data, wdat_mask);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    wdat_valid = 1'b0;
    wdat_last  = 1'b0;
    if (k <= int'(len)) fail("wr_timeout");
    rsp_ready = 1'b1;
    #1;
    w = 0;
    while (!rsp_valid && w < 20) begin @(negedge clk); #1; w++; end
    if (!rsp_valid) fail("wr_ack_timeout");
    else begin
      check("ack_latency", 128'(w), 0);
      check("ack_write", rsp_write, 1);
      check("ack_last", rsp_last, 1);
      check("ack_data", rsp_data, 0);
      check("ack_err", rsp_err, exp_err);
      check("ack_wdat_ready", wdat_ready, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    #3;
    check("wr_done_ready", req_ready, 1);
    check_acc(base, int'(len), wrap, 1'b1);
  endtask

  typedef struct {
    bit          wr;
    logic [55:0] addr;
    logic [2:0]  len;
    bit          wrap;
    int          last_pos;
    bit          fixed;
    int          mode;
    bit          exp_err;
    logic [51:0] exp_last;
  } vec_t;

  function automatic vec_t mk(input bit wr, input logic [55:0] addr, input logic [2:0] len,
                              input bit wrap, input int lp, input bit fx, input int mode,
                              input bit ee, input logic [51:0] el);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.wrap = wrap; v.last_pos = lp;
    v.fixed = fx; v.mode = mode; v.exp_err = ee; v.exp_last = el;
    return v;
  endfunction

  initial begin : main
    vec_t tbl[13];
    logic [52:0] tail;
    logic [127:0] iw;
    int hs, e, lp;
    logic [2:0] rl;
    logic [51:0] ridx_r;

    rst_n = 1'b0;
    req_valid = 0; req_addr = '0; req_write = 0; req_len = '0; req_wrap = 0;
    wdat_valid = 0; wdat_data = '0; wdat_mask = '0; wdat_last = 0; rsp_ready = 0;

    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pre_en = 1'b1; pre_idx = 10'(i); pre_data = init_word(i);
      ref_mem[i] = init_word(i);
    end
    @(negedge clk);
    pre_en = 1'b0;
    #1;
    check("reset_rsp", {rsp_valid, rsp_last, rsp_write, rsp_err}, 0);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_ctl", {ram_en, ram_wen, wdat_ready}, 0);
    check("reset_idx", {ram_ridx, ram_widx}, 0);
    check("reset_wr_bus", {ram_wdata, ram_wmask}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_req_ready", req_ready, 1);

    // Write data offered while idle must be refused.
    @(negedge clk);
    wdat_valid = 1'b1; wdat_data = '1; wdat_mask = '1;
    #1;
    check("idle_wdat_ready", wdat_ready, 0);
    check("idle_ram_en", {ram_en, ram_wen}, 0);
    @(negedge clk);
    wdat_valid = 1'b0;

    //          wr addr                   len wrap lp fx mode err exp_last
    tbl[0]  = mk(0, 56'h1000,             3, 0, 0, 0, 0, 0, 52'h103);
    tbl[1]  = mk(0, 56'h1020,             3, 1, 0, 0, 0, 0, 52'h101);
    tbl[2]  = mk(0, 56'h1000,             1, 0, 0, 0, 2, 0, 52'h101);
    tbl[3]  = mk(1, 56'h2000,             1, 0, 1, 1, 0, 0, 52'h201);
    tbl[4]  = mk(1, 56'h3000,             2, 0, 1, 0, 0, 1, 52'h302);
    tbl[5]  = mk(0, 56'hFF_FFFF_FFFF_FFF0, 1, 0, 0, 0, 1, 0, 52'h0);
    tbl[6]  = mk(0, 56'h450,              7, 1, 0, 0, 1, 0, 52'h44);
    tbl[7]  = mk(0, 56'h130,              2, 1, 0, 0, 0, 0, 52'h15);
    tbl[8]  = mk(1, 56'h2F0,              1, 1, 1, 0, 0, 0, 52'h2E);
    tbl[9]  = mk(0, 56'h40,               0, 0, 0, 0, 0, 0, 52'h4);
    tbl[10] = mk(1, 56'h500,              7, 0, 8, 0, 0, 1, 52'h57);
    tbl[11] = mk(0, 56'hFF_FFFF_FFFF_FFF0, 3, 1, 0, 0, 1, 0, 52'hF_FFFF_FFFF_FFFE);
    tbl[12] = mk(1, 56'h2F0,              7, 1, 7, 0, 0, 0, 52'h2E);

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr)
        run_write(tbl[i].addr, tbl[i].len, tbl[i].wrap, tbl[i].last_pos, tbl[i].fixed, tbl[i].exp_err);
      else
        run_read(tbl[i].addr, tbl[i].len, tbl[i].wrap, tbl[i].mode);
      if (acc_q.size() > 0) begin
        tail = acc_q[acc_q.size() - 1];
        check("tbl_last_idx", tail[51:0], tbl[i].exp_last);
      end else fail("tbl_no_access");
    end

    // Masked write of 0x201 only touched the low 8 bytes.
    run_read(56'h2010, 3'd0, 1'b0, 0);
    iw = init_word(32'h201);
    check("readback_masked", last_rd, {iw[127:64], {8{8'h22}}});
    run_read(56'h2000, 3'd0, 1'b0, 0);
    check("readback_full", last_rd, {16{8'h11}});

    // Reset in the middle of a 4-beat read.
    acc_q.delete();
    send_req(56'h1000, 1'b0, 3'd3, 1'b0);
    rsp_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 20 && hs < 2; c++) begin
      #1;
      if (rsp_valid && rsp_ready) hs++;
      if (hs < 2) @(negedge clk);
    end
    if (hs < 2) fail("mid_reset_beats");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp", {rsp_valid, rsp_last, rsp_write, rsp_err}, 0);
    check("midrst_rsp_data", rsp_data, 0);
    check("midrst_ctl", {ram_en, ram_wen, wdat_ready}, 0);
    check("midrst_idx", {ram_ridx, ram_widx}, 0);
    check("midrst_wr_bus", {ram_wdata, ram_wmask}, 0);
    @(negedge clk);
    rsp_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    check("midrst_req_ready", req_ready, 1);
    check("midrst_no_rsp", rsp_valid, 0);
    run_read(56'h1030, 3'd0, 1'b0, 0);

    // Random bursts against the reference model.
    for (int t = 0; t < 30; t++) begin
      rl = 3'($urandom_range(0, 7));
      ridx_r = {($urandom_range(0, 3) == 0) ? 42'h3FF_FFFF_FFFF : 42'h0, 10'($urandom_range(0, 1023))};
      if ($urandom_range(0, 1) == 1) begin
        lp = $urandom_range(0, 8);
        e = 0;
        for (int j = 0; j <= int'(rl); j++) if ((j == lp) != (j == int'(rl))) e = 1;
        run_write({ridx_r, 4'($urandom)}, rl, 1'($urandom), lp, 1'b0, 1'(e));
      end else begin
        run_read({ridx_r, 4'($urandom)}, rl, 1'($urandom), 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
